// File: rtl/cla_serial_seq.sv
// Multi-cycle adder/subtractor: one 4-bit carry-lookahead slice is reused
// across the nibbles of a WIDTH-bit operand pair, LSB nibble first, with the
// inter-slice carry held in a register. Results are held until the next
// accepted op.

// 4-bit carry-lookahead slice with group generate/propagate outputs.
module cla_4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       g_o,
    output logic       p_o
);
    logic [3:0] p, g, c;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    assign c[0] = c_i;
    assign c[1] = g[0] | (p[0] & c_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_i);

    assign s_o = p ^ c;
    assign g_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);
    assign p_o = &p;
endmodule

module cla_serial_seq #(
    parameter int WIDTH = 16   // multiple of 4, >= 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             zero_o
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDX_W  = $clog2(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             cout_q, ovf_q, zero_q;

    logic [3:0]       slice_a, slice_b, slice_s;
    logic             slice_g, slice_p, slice_co;
    logic [WIDTH-1:0] sum_d;
    logic             accept, last;

    assign ready_o = (state_q != S_RUN);
    assign done_o  = (state_q == S_DONE);
    assign accept  = start_i & ready_o;
    assign last    = (idx_q == LAST_IDX);

    assign slice_a = a_q[idx_q*4 +: 4];
    assign slice_b = b_q[idx_q*4 +: 4];

    cla_4 u_slice (
        .a_i (slice_a),
        .b_i (slice_b),
        .c_i (carry_q),
        .s_o (slice_s),
        .g_o (slice_g),
        .p_o (slice_p)
    );

    // Slice carry-out from group lookahead terms.
    assign slice_co = slice_g | (slice_p & carry_q);

    // Merge the current slice result into the running sum.
    always_comb begin
        sum_d = sum_q;
        sum_d[idx_q*4 +: 4] = slice_s;
    end

    // Controller FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= slice_co;
                    if (last) begin
                        // b_q already holds the inverted operand for sub.
                        idx_q   <= '0;
                        cout_q  <= slice_co;
                        zero_q  <= (sum_d == '0);
                        ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &
                                   (slice_s[3] != a_q[WIDTH-1]);
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE: launch on start, otherwise rest in IDLE.
                    if (accept) begin
                        a_q     <= a_i;
                        b_q     <= b_i ^ {WIDTH{sub_i}};
                        carry_q <= sub_i;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;
    assign zero_o = zero_q;
endmodule
